run_step_scheduler: RTL and testbench

- Shares one three-phase stepping FSM (phases Init=0, A=1, B=2, advanced by one `run` pulse each) among NREQ requesters.
- Each requester asks for a number of steps. The block arbitrates round-robin, issues that many `run` pulses spaced by GAP idle cycles, and mirrors the FSM phase internally.
- It signals completion with a one-cycle done pulse and the owner id.
- It sits directly upstream of the stepping FSM and drives its `run` input.

---
 rtl/run_step_scheduler_if.sv | 28 ++
 rtl/run_step_scheduler.sv | 105 ++++++++++
 tb/tb_run_step_scheduler.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/run_step_scheduler_if.sv
// Request/grant and step-pulse bundle shared by the requesters and the run-step scheduler.
// Master is the requester side, slave is the scheduler.
interface run_step_scheduler_if #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned CW   = 4
);
   localparam int unsigned IW = $clog2(NREQ);

   logic [NREQ-1:0]    req;
   logic [NREQ*CW-1:0] steps;
   logic [NREQ-1:0]    gnt;
   logic               run;
   logic [1:0]         phase;
   logic               phase_b;
   logic               busy;
   logic               done;
   logic [IW-1:0]      done_id;

   modport master (
      output req, steps,
      input  gnt, run, phase, phase_b, busy, done, done_id
   );

   modport slave (
      input  req, steps,
      output gnt, run, phase, phase_b, busy, done, done_id
   );
endinterface

// File: rtl/run_step_scheduler.sv
// Round-robin scheduler sharing one three-phase stepping FSM among NREQ requesters.
// Issues the granted number of run pulses spaced by GAP idle cycles and mirrors the FSM phase.
module run_step_scheduler #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned CW   = 4,
   parameter int unsigned GAP  = 1
) (
   input logic                 i_clk,
   input logic                 i_reset,
   run_step_scheduler_if.slave bus
);
   localparam int unsigned IW = $clog2(NREQ);
   localparam logic [3:0] GapLoad = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StPulse = 2'd1,
      StGap   = 2'd2,
      StDone  = 2'd3
   } state_e;

   state_e          r_state;
   logic [NREQ-1:0] r_gnt;
   logic [IW-1:0]   r_owner;
   logic [IW-1:0]   r_rr;
   logic [CW-1:0]   r_remaining;
   logic [3:0]      r_gap_cnt;
   logic [1:0]      r_phase;

   logic            w_found;
   logic [IW-1:0]   w_win;
   int unsigned     w_idx;
   logic [CW-1:0]   w_win_steps;

   // First requester at or above the rr pointer, wrapping at NREQ.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_idx   = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         w_idx = (32'(r_rr) + k) % NREQ;
         if (!w_found && bus.req[w_idx]) begin
            w_found = 1'b1;
            w_win   = IW'(w_idx);
         end
      end
      w_win_steps = bus.steps[32'(w_win)*CW +: CW];
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state     <= StIdle;
         r_gnt       <= '0;
         r_owner     <= '0;
         r_rr        <= '0;
         r_remaining <= '0;
         r_gap_cnt   <= '0;
         r_phase     <= 2'd0;
      end else begin
         case (r_state)
            StIdle: begin
               if (w_found) begin
                  r_gnt       <= NREQ'(1) << w_win;
                  r_owner     <= w_win;
                  r_remaining <= w_win_steps;
                  r_state     <= (w_win_steps != '0) ? StPulse : StDone;
               end
            end
            StPulse: begin
               r_phase     <= (r_phase == 2'd0) ? 2'd1 : (r_phase == 2'd1) ? 2'd2 : 2'd0;
               r_remaining <= r_remaining - CW'(1);
               if (r_remaining == CW'(1)) begin
                  r_state <= StDone;
               end else if (GAP > 0) begin
                  r_state   <= StGap;
                  r_gap_cnt <= GapLoad;
               end else begin
                  r_state <= StPulse;
               end
            end
            StGap: begin
               if (r_gap_cnt == 4'd0) begin
                  r_state <= StPulse;
               end else begin
                  r_gap_cnt <= r_gap_cnt - 4'd1;
               end
            end
            StDone: begin
               r_gnt   <= '0;
               r_rr    <= (r_owner == IW'(NREQ - 1)) ? '0 : r_owner + IW'(1);
               r_state <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign bus.gnt     = r_gnt;
   assign bus.run     = (r_state == StPulse);
   assign bus.phase   = r_phase;
   assign bus.phase_b = (r_phase == 2'd2);
   assign bus.busy    = (r_state != StIdle);
   assign bus.done    = (r_state == StDone);
   assign bus.done_id = r_owner;
endmodule

// File: tb/tb_run_step_scheduler.sv
// Scoreboard bench for run_step_scheduler: stimulus pushes expected completions, a negedge
// monitor pops and checks them on every done pulse.
module tb_run_step_scheduler;
   localparam int unsigned NREQ = 4;
   localparam int unsigned CW   = 4;
   localparam int unsigned GAP  = 1;

   logic clk;
   logic rst_n;

   run_step_scheduler_if #(.NREQ(NREQ), .CW(CW)) bus ();

   run_step_scheduler #(.NREQ(NREQ), .CW(CW), .GAP(GAP)) dut (
      .i_clk   (clk),
      .i_reset (rst_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int id;
      int pulses;
      int ph;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   model_phase = 0;

   task automatic chk(input string nm, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
      end
   endtask

   task automatic timeout(input string nm);
      checks++;
      errors++;
      $display("FAIL %s: timed out waiting (t=%0t)", nm, $time);
   endtask

   task automatic push_exp(input int id, input int n);
      exp_t e;
      e.id   = id;
      e.pulses = n;
      e.ph   = (model_phase + n) % 3;
      model_phase = e.ph;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      model_phase = 0;
   endtask

   task automatic wait_gnt(input logic [NREQ-1:0] g, input string nm);
      int n = 0;
      while (bus.gnt !== g && n < 100) begin
         tick();
         n++;
      end
      if (bus.gnt !== g) timeout(nm);
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while ((bus.busy !== 1'b0 || exp_q.size() != 0) && n < 300) begin
         tick();
         n++;
      end
      if (bus.busy !== 1'b0 || exp_q.size() != 0) timeout(nm);
   endtask

   // Monitor: pulse spacing, idle-after-done, and completion scoreboard
   int cyc = 0;
   int pulse_cnt = 0;
   int last_run = 0;
   bit d1 = 0;
   bit d2 = 0;
   bit rq1 = 0;

   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (!rst_n) begin
         pulse_cnt = 0;
         d1 = 0;
         d2 = 0;
         rq1 = 0;
      end else begin
         chk("phase_b_decode", int'(bus.phase_b), int'(bus.phase == 2'd2));
         if (d1) chk("idle_after_done", int'(bus.busy), 0);
         if (d2 && rq1) chk("regrant_after_idle", int'(bus.busy), 1);
         if (bus.run) begin
            if (pulse_cnt > 0) chk("pulse_spacing", cyc - last_run, GAP + 1);
            pulse_cnt++;
            last_run = cyc;
         end
         if (bus.done) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", int'(bus.done), 0);
            end else begin
               e = exp_q.pop_front();
               chk("done_id", int'(bus.done_id), e.id);
               chk("pulse_count", pulse_cnt, e.pulses);
               chk("phase_at_done", int'(bus.phase), e.ph);
               chk("gnt_at_done", int'(bus.gnt), 1 << e.id);
            end
            pulse_cnt = 0;
         end
         d2 = d1;
         d1 = bus.done;
         rq1 = (bus.req != '0);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   int t2_run[6]   = '{1, 0, 1, 0, 1, 0};
   int t2_phase[6] = '{0, 1, 1, 2, 2, 0};
   int t2_done[6]  = '{0, 0, 0, 0, 0, 1};

   initial begin
      int ng;
      int quiet;
      logic [NREQ-1:0] prev;

      // Reset held with all requests pending
      rst_n = 1'b0;
      bus.req = 4'b1111;
      bus.steps = 16'h0000;
      tick();
      tick();
      chk("rst_gnt", int'(bus.gnt), 0);
      chk("rst_run", int'(bus.run), 0);
      chk("rst_phase", int'(bus.phase), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      push_exp(0, 0);
      rst_n = 1'b1;
      tick();
      chk("rst_first_gnt", int'(bus.gnt), 1);
      bus.req = '0;
      wait_idle("t1_idle");

      // Single request, 3 steps, cycle-accurate
      bus.steps = 16'h0030;
      bus.req = 4'b0010;
      push_exp(1, 3);
      tick();
      bus.req = '0;
      for (int i = 0; i < 6; i++) begin
         chk("t2_gnt", int'(bus.gnt), 2);
         chk("t2_run", int'(bus.run), t2_run[i]);
         chk("t2_phase", int'(bus.phase), t2_phase[i]);
         chk("t2_done", int'(bus.done), t2_done[i]);
         tick();
      end
      chk("t2_idle_busy", int'(bus.busy), 0);
      chk("t2_idle_gnt", int'(bus.gnt), 0);
      wait_idle("t2_idle");

      // Simultaneous requests from pointer 0
      do_reset();
      bus.steps = 16'h0101;
      bus.req = 4'b0101;
      push_exp(0, 1);
      push_exp(2, 1);
      wait_gnt(4'b0100, "t3_gnt2");
      bus.req = '0;
      wait_idle("t3_idle");

      // Fairness with all requests held
      do_reset();
      bus.steps = 16'h2222;
      bus.req = 4'b1111;
      push_exp(0, 2);
      push_exp(1, 2);
      push_exp(2, 2);
      push_exp(3, 2);
      push_exp(0, 2);
      ng = 0;
      prev = '0;
      for (int n = 0; n < 300 && ng < 5; n++) begin
         tick();
         if (bus.gnt != '0 && prev == '0) ng++;
         prev = bus.gnt;
      end
      bus.req = '0;
      if (ng < 5) timeout("t4_grants");
      wait_idle("t4_idle");

      // Zero step count: straight to done, no pulse
      bus.steps = 16'h0000;
      bus.req = 4'b1000;
      push_exp(3, 0);
      wait_gnt(4'b1000, "t5_gnt");
      bus.req = '0;
      chk("t5_done_now", int'(bus.done), 1);
      chk("t5_no_run", int'(bus.run), 0);
      wait_idle("t5_idle");

      // Reset during the second pulse aborts the service silently
      bus.steps = 16'h0005;
      bus.req = 4'b0001;
      tick();
      bus.req = '0;
      chk("t6_gnt", int'(bus.gnt), 1);
      chk("t6_pulse1", int'(bus.run), 1);
      tick();
      chk("t6_gap", int'(bus.run), 0);
      tick();
      chk("t6_pulse2", int'(bus.run), 1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      model_phase = 0;
      chk("t6_phase", int'(bus.phase), 0);
      chk("t6_gnt_clr", int'(bus.gnt), 0);
      chk("t6_busy", int'(bus.busy), 0);
      quiet = 0;
      for (int n = 0; n < 10; n++) begin
         tick();
         if (bus.run || bus.done) quiet++;
      end
      chk("t6_quiet", quiet, 0);

      chk("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
